// File: rtl/rr_arb_pkg.sv
// Shared types and sizes for the round-robin mux arbiter.
// Optional feature macro used by rr_mux_arbiter: RR_MUX_ARBITER_CNT_EN.
package rr_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;
    localparam int CNT_W = 8;

    typedef logic [SEL_W-1:0] sel_t;

    // Occupancy of the single-entry output register.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotate-and-priority-encode: returns the first set request at or after
// 'start', wrapping from the top index back to 0.
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  sel_t             start,
    output logic             any,
    output sel_t             grant
);

    // Scan from the far end toward start so the nearest set request wins last.
    always_comb begin
        sel_t idx;
        any   = 1'b0;
        grant = start;
        idx   = start;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = start + sel_t'(k);
            if (req[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Four-requester round-robin arbiter feeding a single-entry output register.
// Handshake: a word moves on any side when valid and ready are both high at
// the rising clock edge; req_ready is one-hot (or zero) and combinational.
// Optional macro RR_MUX_ARBITER_CNT_EN adds per-requester 8-bit grant counters.
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output sel_t                      out_sel,
    input  logic                      out_ready
`ifdef RR_MUX_ARBITER_CNT_EN
    ,
    output logic [N_REQ*CNT_W-1:0]    grant_cnt
`endif
);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    sel_t               out_sel_q, out_sel_d;
    sel_t               last_grant_q, last_grant_d;

    logic               can_load;
    logic               pick_any;
    sel_t               pick_grant;
    sel_t               pick_start;
    logic               xfer;
    logic [N_REQ-1:0]   grant_oh;
    logic [DATA_W-1:0]  data_arr [N_REQ];

    // Search begins one past the most recent winner.
    assign pick_start = last_grant_q + sel_t'(1);

    rr_pick u_pick (
        .req   (req_valid),
        .start (pick_start),
        .any   (pick_any),
        .grant (pick_grant)
    );

    // Unpack the flat data bus into an index-addressable array.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            data_arr[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Accept strobe: only when the register can take a word and not in reset.
    always_comb begin
        can_load = (state_q == EMPTY) || out_ready;
        xfer     = !rst && can_load && pick_any;
        grant_oh = '0;
        grant_oh[pick_grant] = 1'b1;
        req_ready = xfer ? grant_oh : '0;
    end

    // Next-state for the output register and the rotating priority pointer.
    always_comb begin
        state_d      = state_q;
        out_data_d   = out_data_q;
        out_sel_d    = out_sel_q;
        last_grant_d = last_grant_q;
        if (xfer) begin
            state_d      = FULL;
            out_data_d   = data_arr[pick_grant];
            out_sel_d    = pick_grant;
            last_grant_d = pick_grant;
        end else if (state_q == FULL && out_ready) begin
            // Drain without refill: data and index keep their last values.
            state_d = EMPTY;
        end
    end

    // State registers; reset points the pointer at 3 so requester 0 goes first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            out_data_q   <= '0;
            out_sel_q    <= '0;
            last_grant_q <= sel_t'(N_REQ - 1);
        end else begin
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_sel_q    <= out_sel_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

`ifdef RR_MUX_ARBITER_CNT_EN
    logic [CNT_W-1:0] cnt_q [N_REQ];
    logic [CNT_W-1:0] cnt_d [N_REQ];

    // Bump the winner's counter on each transfer; wraps naturally at 255.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (xfer) begin
            cnt_d[pick_grant] = cnt_q[pick_grant] + CNT_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Pack counters onto the flat output.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter: per-cycle stimulus table plus hand sequences.
// Optional macro RR_MUX_ARBITER_CNT_EN also exercises the grant counters.
module tb_rr_mux_arbiter;
    import rr_arb_pkg::*;

    localparam int W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         req_valid;
    logic [4*W-1:0]     req_data;
    logic [3:0]         req_ready;
    logic               out_valid;
    logic [W-1:0]       out_data;
    sel_t               out_sel;
    logic               out_ready;
`ifdef RR_MUX_ARBITER_CNT_EN
    logic [31:0]        grant_cnt;
`endif

    rr_mux_arbiter #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
`ifdef RR_MUX_ARBITER_CNT_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [3:0] v;
        logic       rdy;
        logic [3:0] exp_rdy;
    } vec_t;

    vec_t              vecs[$];
    logic [SEL_W+W-1:0] exp_q[$];

    int n_chk = 0;
    int n_err = 0;

    // Reference view of the output register
    logic         held_v;
    logic [W-1:0] held_d;
    sel_t         held_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input logic r, input logic [3:0] v, input logic rdy,
                                input logic [3:0] er);
        vec_t x;
        x.r = r; x.v = v; x.rdy = rdy; x.exp_rdy = er;
        vecs.push_back(x);
    endfunction

    // One clock of stimulus: check req_ready mid-cycle, then the output register.
    task automatic run_cycle(input logic r, input logic [3:0] v, input logic rdy,
                             input logic [3:0] er, input logic [4*W-1:0] dat);
        logic [SEL_W+W-1:0] e;
        sel_t idx;
        rst = r; req_valid = v; out_ready = rdy; req_data = dat;
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(er));
        if (er != 4'b0000) begin
            idx = '0;
            for (int i = 0; i < 4; i++) if (er[i]) idx = sel_t'(i);
            exp_q.push_back({idx, dat[int'(idx)*W +: W]});
        end
        @(posedge clk);
        #1;
        if (r) begin
            held_v = 1'b0; held_d = '0; held_s = '0;
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            held_v = 1'b1; held_s = e[SEL_W+W-1:W]; held_d = e[W-1:0];
        end else if (rdy) begin
            held_v = 1'b0;
        end
        chk("out_valid", 32'(out_valid), 32'(held_v));
        chk("out_data", 32'(out_data), 32'(held_d));
        chk("out_sel", 32'(out_sel), 32'(held_s));
    endtask

    function automatic logic [4*W-1:0] rand_data();
        logic [4*W-1:0] d;
        for (int i = 0; i < 4; i++) d[i*W +: W] = W'($urandom_range(0, 255));
        return d;
    endfunction

    initial begin
        logic [4*W-1:0] d7;
        rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
        held_v = 1'b0; held_d = '0; held_s = '0;
        @(posedge clk);
        #1;

        // reset, then all four active: 0,1,2,3,0
        add(1, 4'b1111, 1, 4'b0000);
        add(1, 4'b1111, 1, 4'b0000);
        add(0, 4'b1111, 1, 4'b0001);
        add(0, 4'b1111, 1, 4'b0010);
        add(0, 4'b1111, 1, 4'b0100);
        add(0, 4'b1111, 1, 4'b1000);
        add(0, 4'b1111, 1, 4'b0001);
        // sparse 1010: 1,3,1,3
        add(0, 4'b1010, 1, 4'b0010);
        add(0, 4'b1010, 1, 4'b1000);
        add(0, 4'b1010, 1, 4'b0010);
        add(0, 4'b1010, 1, 4'b1000);
        add(0, 4'b0010, 1, 4'b0010);
        // drain only, idle, then priority resumes at 2
        add(0, 4'b0000, 1, 4'b0000);
        add(0, 4'b0000, 0, 4'b0000);
        add(0, 4'b1111, 0, 4'b0100);
        add(0, 4'b1111, 0, 4'b0000);
        add(0, 4'b1111, 1, 4'b1000);
        // absent requester 0 is skipped
        add(0, 4'b0000, 1, 4'b0000);
        add(0, 4'b0010, 1, 4'b0010);
        // single requester wins every cycle
        add(0, 4'b0100, 1, 4'b0100);
        add(0, 4'b0100, 1, 4'b0100);
        add(0, 4'b0100, 1, 4'b0100);
        // full and stalled, then reset mid-operation
        add(0, 4'b1111, 0, 4'b0000);
        add(1, 4'b1111, 1, 4'b0000);
        add(0, 4'b1111, 1, 4'b0001);

        foreach (vecs[k]) run_cycle(vecs[k].r, vecs[k].v, vecs[k].rdy, vecs[k].exp_rdy, rand_data());

        // stall holding 'h7 from requester 2, then requester 3 goes next
        d7 = rand_data();
        d7[2*W +: W] = W'(8'h07);
        run_cycle(0, 4'b0100, 1, 4'b0100, d7);
        for (int c = 0; c < 5; c++) begin
            run_cycle(0, 4'b1111, 0, 4'b0000, rand_data());
            chk("stall_data", 32'(out_data), 32'h7);
            chk("stall_sel", 32'(out_sel), 32'd2);
        end
        run_cycle(0, 4'b1111, 1, 4'b1000, rand_data());

`ifdef RR_MUX_ARBITER_CNT_EN
        run_cycle(1, 4'b0000, 0, 4'b0000, rand_data());
        for (int c = 0; c < 300; c++) run_cycle(0, 4'b0010, 1, 4'b0010, rand_data());
        chk("grant_cnt", grant_cnt, 32'h0000_2c00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter list SHALL be: DATA_W, 4, width of each requester data word.
REQ-002 Clock and reset SHALL be: one clock; reset is synchronous and active-high. Ports are clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-003 Port list SHALL be:
- req_valid   input   4         per-requester valid; bit i = requester i
- req_data    input   4*DATA_W  packed data; slice [i*DATA_W +: DATA_W] = requester i
- req_ready   output  4         per-requester accept strobe, one-hot or zero
- out_valid   output  1         output register holds a word
- out_data    output  DATA_W    selected word
- out_sel     output  2         index of the requester that supplied out_data
- out_ready   input   1         consumer accepts the word

Function
REQ-004 Arbitration SHALL be round-robin over 4 requesters. The search starts at (last_grant+1) mod 4 and wraps 3->0.
REQ-005 The block SHALL hold a single-entry output register with states EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-006 can_load SHALL be defined as (state==EMPTY) or (out_valid and out_ready).
REQ-007 When can_load=1 and any req_valid=1, req_ready SHALL assert combinationally and one-hot for the winning requester only. Otherwise req_ready SHALL be 4'b0000.
REQ-008 A transfer on requester i occurs when req_valid[i] and req_ready[i]. On that edge the block SHALL load out_data=req_data slice i, out_sel=i and out_valid=1, and set last_grant=i. Latency is 1 cycle.
REQ-009 A simultaneous drain (out_valid and out_ready) and load SHALL keep the state FULL with the new word, giving 1 word/cycle throughput.
REQ-010 A drain with no load SHALL go FULL->EMPTY and clear out_valid. out_data and out_sel SHALL hold their last values.
REQ-011 While FULL and out_ready=0, out_valid, out_data and out_sel SHALL stay stable, and req_ready SHALL be 0.
REQ-012 last_grant SHALL update only on a transfer. Idle cycles SHALL NOT rotate priority.
REQ-013 With only one requester active, that requester SHALL win every cycle.
REQ-014 req_valid deasserted before a grant SHALL lose its turn with no state change.

Reset
REQ-015 While rst=1 at a clock edge, the block SHALL set out_valid=0, out_data=0, out_sel=0, last_grant=3 (so the first search starts at 0), and state EMPTY.
REQ-016 req_ready SHALL be forced to 0 in any cycle where rst=1.
REQ-017 Reset asserted mid-transfer SHALL discard the held word. No transfer SHALL be recorded in that cycle.

Configuration
REQ-018 Macro RR_MUX_ARBITER_CNT_EN defined: the block SHALL add output grant_cnt (32 bits, 4 x 8-bit, slice [i*8 +: 8] = requester i).
- Each counter increments by 1 on every transfer of its requester.
- Each counter wraps 255->0.
- Reset value is 0.
REQ-019 Macro RR_MUX_ARBITER_CNT_EN undefined: the grant_cnt port and counters SHALL be absent. All other behaviour SHALL be identical.

Structure
REQ-020 Package rr_arb_pkg SHALL hold:
- N_REQ=4
- SEL_W=2
- CNT_W=8
- typedef sel_t (logic [SEL_W-1:0])
- enum state_t {EMPTY, FULL}
REQ-021 Sub-module rr_pick SHALL implement the combinational rotate-and-priority-encode. Inputs: req[3:0], start sel_t. Outputs: any, grant sel_t.
REQ-022 Data selection SHALL use an array indexed by the grant index (4:1 mux by index).

Verification
REQ-023 Reset check: after reset, drive req_valid=4'b1111 and out_ready=1 with data a,b,c,d.
- Required: grants 0,1,2,3,0 on consecutive cycles.
- Required: out_data a,b,c,d,a, one cycle later each.
REQ-024 Stall check: out_ready=0 with FULL holding 'h7 from requester 2 for 5 cycles.
- Required: out_data='h7, out_sel=2 and req_ready=0 throughout.
- Required: on out_ready=1, the next grant is requester 3 if valid.
REQ-025 Sparse check: req_valid=4'b1010.
- Required: alternating grants 1,3,1,3.
- Required: requesters 0 and 2 never see req_ready.
REQ-026 Drain-only check: FULL, out_ready=1, req_valid=0.
- Required: out_valid drops next cycle.
- Required: last_grant is unchanged, so the next request from (last_grant+1) wins first.
REQ-027 Mid-operation reset: assert rst while FULL and req_valid=4'b1111.
- Required: out_valid=0 and req_ready=0 that cycle.
- Required: after release, the first grant is requester 0.
REQ-028 With RR_MUX_ARBITER_CNT_EN defined: 300 transfers from requester 1 only SHALL give grant_cnt slice 1 = 44, with other slices 0.
